// File: rtl/rv_branch_predictor.sv
// Bimodal (or gshare with RV_BP_GSHARE_EN) direction predictor: 2-bit saturating counters
// indexed by PC, swept to CTR_RST after reset, trained by EX-stage branch outcomes.
module rv_branch_predictor #(
   parameter int unsigned IDX_W   = 6,
   parameter int unsigned BUS_W   = 32,
   parameter logic [1:0]  CTR_RST = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetchValid,
   input  logic [BUS_W-1:0] fetchPc,
   output logic             predValid,
   output logic             predTaken,
   output logic             bpReady,
   input  logic             exValid,
   input  logic [BUS_W-1:0] exPc,
   input  logic             exTaken,
   input  logic             exPredTaken,
   output logic             mispredict
);

   localparam int unsigned ENTRIES = 1 << IDX_W;

   typedef enum logic {StInit, StRun} state_t;

   state_t           r_state;
   state_t           w_state_d;
   logic [IDX_W-1:0] r_ptr;
   logic [1:0]       r_table [ENTRIES];
   logic             r_pred_valid;
   logic             r_pred_taken;
   logic             r_mispredict;

   logic [IDX_W-1:0] w_hist;
   logic [IDX_W-1:0] w_fetch_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic [1:0]       w_ctr_old;
   logic [1:0]       w_ctr_new;
   logic             w_update;
   logic             w_unused_bits;

`ifdef RV_BP_GSHARE_EN
   logic [IDX_W-1:0] r_ghr;

   // History shifts on the same edge as the counter write, so the update indexes with old GHR.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ghr <= '0;
      end else if (w_update) begin
         r_ghr <= {r_ghr[IDX_W-2:0], exTaken};
      end
   end

   assign w_hist = r_ghr;
`else
   assign w_hist = '0;
`endif

   assign w_fetch_idx   = fetchPc[IDX_W+1:2] ^ w_hist;
   assign w_ex_idx      = exPc[IDX_W+1:2] ^ w_hist;
   assign w_update      = exValid && (r_state == StRun);
   assign w_ctr_old     = r_table[w_ex_idx];
   assign w_unused_bits = ^{fetchPc[BUS_W-1:IDX_W+2], fetchPc[1:0],
                            exPc[BUS_W-1:IDX_W+2], exPc[1:0]};

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StInit:  if (&r_ptr) w_state_d = StRun;
         StRun:   w_state_d = StRun;
         default: w_state_d = StInit;
      endcase
   end

   always_comb begin
      w_ctr_new = w_ctr_old;
      if (exTaken) begin
         if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'd1;
      end else if (w_ctr_old != 2'b00) begin
         w_ctr_new = w_ctr_old - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StInit;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StInit) r_ptr <= r_ptr + 1'b1;
      end
   end

   // Table has no reset of its own; the init sweep rewrites every entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == StInit) begin
            r_table[r_ptr] <= CTR_RST;
         end else if (exValid) begin
            r_table[w_ex_idx] <= w_ctr_new;
         end
      end
   end

   // Lookup reads the pre-update counter; no same-cycle bypass from the EX write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_mispredict <= 1'b0;
      end else begin
         r_pred_valid <= fetchValid;
         r_pred_taken <= fetchValid && (r_state == StRun) && r_table[w_fetch_idx][1];
         r_mispredict <= exValid && (exPredTaken ^ exTaken);
      end
   end

   assign predValid  = r_pred_valid;
   assign predTaken  = r_pred_taken;
   assign mispredict = r_mispredict;
   assign bpReady    = (r_state == StRun);

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Scoreboard bench for rv_branch_predictor: driver pushes reference-model expectations,
// monitor pops and compares after each rising edge.
module tb_rv_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetchValid = 1'b0;
   logic [31:0] fetchPc = '0;
   logic        predValid;
   logic        predTaken;
   logic        bpReady;
   logic        exValid = 1'b0;
   logic [31:0] exPc = '0;
   logic        exTaken = 1'b0;
   logic        exPredTaken = 1'b0;
   logic        mispredict;

   rv_branch_predictor dut (
      .clk         (clk),
      .rst         (rst),
      .fetchValid  (fetchValid),
      .fetchPc     (fetchPc),
      .predValid   (predValid),
      .predTaken   (predTaken),
      .bpReady     (bpReady),
      .exValid     (exValid),
      .exPc        (exPc),
      .exTaken     (exTaken),
      .exPredTaken (exPredTaken),
      .mispredict  (mispredict)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic pv;
      logic mis;
      logic rdy;
   } cyc_exp_t;

   cyc_exp_t cyc_q[$];
   logic     pred_q[$];
   int       n_checks = 0;
   int       n_pass   = 0;

   // Reference model: counters as plain integers 0..3, init as a count of swept entries.
   int       m_tbl [64];
   int       m_swept = 0;
   bit       m_run   = 0;
   int       m_ghr   = 0;

   function automatic int m_idx(input logic [31:0] pc);
      int i;
      i = int'(pc[7:2]);
`ifdef RV_BP_GSHARE_EN
      i = i ^ m_ghr;
`endif
      return i;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic cycle(input bit r, input bit fv, input logic [31:0] fpc, input bit ev,
                        input logic [31:0] epc, input bit et, input bit ept);
      cyc_exp_t e;
      int       i;
      @(negedge clk);
      rst = r; fetchValid = fv; fetchPc = fpc;
      exValid = ev; exPc = epc; exTaken = et; exPredTaken = ept;
      if (r) begin
         m_run = 0; m_swept = 0; m_ghr = 0;
         e = '{pv: 1'b0, mis: 1'b0, rdy: 1'b0};
      end else begin
         if (fv) pred_q.push_back(m_run && m_tbl[m_idx(fpc)] >= 2);
         e.pv  = fv;
         e.mis = ev && (et != ept);
         if (m_run) begin
            if (ev) begin
               i = m_idx(epc);
               m_tbl[i] = et ? ((m_tbl[i] < 3) ? m_tbl[i] + 1 : 3)
                             : ((m_tbl[i] > 0) ? m_tbl[i] - 1 : 0);
               m_ghr = ((m_ghr << 1) | int'(et)) & 63;
            end
         end else begin
            m_tbl[m_swept] = 1;
            m_swept++;
            if (m_swept == 64) m_run = 1;
         end
         e.rdy = m_run;
      end
      cyc_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cycle(0, 0, 32'h0, 0, 32'h0, 0, 0);
   endtask

   task automatic fetch(input logic [31:0] pc);
      cycle(0, 1, pc, 0, 32'h0, 0, 0);
   endtask

   task automatic train(input logic [31:0] pc, input bit taken, input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 32'h0, 1, pc, taken, 1'($urandom));
   endtask

   // Counts edges from reset release until bpReady, with random fetches during the sweep.
   task automatic reset_and_count(input string name, input int pre_cycles);
      int n;
      cycle(1, 0, 32'h0, 1, 32'h100, 1, 0);
      for (int k = 0; k < pre_cycles; k++) cycle(0, 1'($urandom), $urandom, 1, 32'h100, 1, 0);
      if (pre_cycles > 0) begin
         check({name, "_ready_midsweep"}, int'(bpReady), 0);
         cycle(1, 1, 32'h100, 1, 32'h100, 1, 1);
         check({name, "_ready_after_rst"}, int'(bpReady), 0);
      end
      n = 0;
      do begin
         cycle(0, 1'($urandom), $urandom, 1'($urandom), 32'h100, 1'($urandom), 1'($urandom));
         n++;
      end while (!bpReady && n < 200);
      check({name, "_init_cycles"}, n, 64);
   endtask

   initial begin
      cyc_exp_t e;
      logic     p;
      forever begin
         @(posedge clk);
         #1;
         if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("predValid", int'(predValid), int'(e.pv));
            check("mispredict", int'(mispredict), int'(e.mis));
            check("bpReady", int'(bpReady), int'(e.rdy));
         end
         if (predValid === 1'b1) begin
            if (pred_q.size() == 0) begin
               check("pred_unexpected", 1, 0);
            end else begin
               p = pred_q.pop_front();
               check("predTaken", int'(predTaken), int'(p));
            end
         end else begin
            check("predTaken_idle", int'(predTaken), 0);
         end
      end
   end

   initial begin
      // Reset and sweep
      reset_and_count("init", 0);

      // Training and saturation on 0x100
      fetch(32'h100);
      train(32'h100, 1, 2);
      fetch(32'h100);
      train(32'h100, 1, 5);
      fetch(32'h100);
      train(32'h100, 0, 2);
      fetch(32'h100);

      // Aliasing 0x200 onto 0x100
      train(32'h200, 1, 3);
      fetch(32'h100);
      fetch(32'h200);

      // Explicit mispredict pulses
      cycle(0, 0, 32'h0, 1, 32'h300, 1, 0);
      idle();
      cycle(0, 0, 32'h0, 1, 32'h300, 1, 1);
      cycle(0, 0, 32'h0, 1, 32'h300, 0, 1);
      idle();

      // Reset mid-sweep, then reset in RUN after training
      reset_and_count("midsweep", 30);
      train(32'h100, 1, 3);
      fetch(32'h100);
      reset_and_count("runrst", 0);
      fetch(32'h100);

      // Same-cycle lookup and update to 0x40: old value returned
      cycle(0, 1, 32'h40, 1, 32'h40, 1, 0);
      fetch(32'h40);
      cycle(0, 1, 32'h40, 1, 32'h40, 1, 1);
      fetch(32'h40);

      // Random traffic over a few hot PCs
      for (int k = 0; k < 600; k++) begin
         logic [31:0] fpc;
         logic [31:0] epc;
         fpc = (($urandom % 4) == 0) ? $urandom : {24'h0, 2'($urandom), 4'($urandom), 2'b00};
         epc = (($urandom % 4) == 0) ? $urandom : {24'h0, 2'($urandom), 4'($urandom), 2'b00};
         if ($urandom_range(0, 299) == 0)
            cycle(1, 1'($urandom), fpc, 1'($urandom), epc, 1'($urandom), 1'($urandom));
         else
            cycle(0, 1'($urandom), fpc, 1'($urandom), epc, 1'($urandom), 1'($urandom));
      end

      idle();
      idle();
      check("pred_q_drained", pred_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
